id_ex_stage: RTL

- ID/EX pipeline register of the 5-stage MIPS pipeline. Sits directly upstream of the ALU and drives its operand inputs (alu_data_in_1, alu_data_in_2) and its 4-bit op.
- Registers decoded ID fields and applies stall and flush.
- Detects load-use hazards and inserts the bubble.
- Performs EX/MEM and MEM/WB operand forwarding, and decodes ALUOp/funct into the ALU op code.

---
 rtl/id_ex_stage_pkg.sv | 28 ++
 rtl/id_ex_stage_alu_control.sv | 33 +++
 rtl/id_ex_stage.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: ALU op codes, main-decoder ALUOp
// encodings and the R-type funct values understood by the ALU control.
package id_ex_stage_pkg;

    // ALU op codes presented to the ALU
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOP = 4'd15;

    // ALUOp field produced by the main decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_SLT   = 2'b11
    } aluop_t;

    // R-type funct codes
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

endpackage

// File: rtl/id_ex_stage_alu_control.sv
// ALU control: turns the main-decoder ALUOp plus the R-type funct field
// into the 4-bit ALU op code. Purely combinational.
module id_ex_stage_alu_control
    import id_ex_stage_pkg::*;
(
    input  logic [1:0] alu_ctrl_op,
    input  logic [5:0] funct,
    output logic [3:0] op
);

    // Non-R-type ALUOps select a fixed op; R-type defers to funct, and an
    // unknown funct maps to NOP so the ALU produces zero.
    always_comb begin
        op = ALU_NOP;
        case (aluop_t'(alu_ctrl_op))
            ALUOP_ADD: op = ALU_ADD;
            ALUOP_SUB: op = ALU_SUB;
            ALUOP_SLT: op = ALU_SLT;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: op = ALU_ADD;
                    FUNCT_SUB: op = ALU_SUB;
                    FUNCT_AND: op = ALU_AND;
                    FUNCT_OR:  op = ALU_OR;
                    FUNCT_SLT: op = ALU_SLT;
                    default:   op = ALU_NOP;
                endcase
            end
            default: op = ALU_NOP;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS pipeline. Captures decoded
// ID fields, handles stall/flush and load-use bubbles, forwards operands
// from EX/MEM and MEM/WB, and decodes the ALU op for the EX stage.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc_plus4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_branch,
    input  logic [1:0]        id_alu_ctrl_op,
    input  logic              exmem_reg_write,
    input  logic [REG_W-1:0]  exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_W-1:0]  memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              load_use_hazard,
    output logic              ex_valid,
    output logic [DATA_W-1:0] alu_data_in_1,
    output logic [DATA_W-1:0] alu_data_in_2,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_W-1:0]  ex_write_reg,
    output logic [DATA_W-1:0] ex_branch_target,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_branch
);

    logic [DATA_W-1:0] ex_pc_plus4;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [REG_W-1:0]  ex_rs;
    logic [REG_W-1:0]  ex_rt;
    logic [REG_W-1:0]  ex_rd;
    logic              ex_alu_src;
    logic              ex_reg_dst;
    logic [1:0]        ex_alu_ctrl_op;
    logic              load_bubble;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // A load in EX whose destination is read by the ID instruction must be
    // separated by one bubble; $0 never creates a dependency.
    always_comb begin
        load_use_hazard = ex_valid & ex_mem_read & id_valid &
                          (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
    end

    // Reset and flush always win; a hazard bubble only happens when not stalled.
    always_comb begin
        load_bubble = !rst_n | flush | (!stall & load_use_hazard);
    end

    // Pipeline register: clear on bubble, hold on stall, otherwise capture ID.
    always_ff @(posedge clk) begin
        if (load_bubble) begin
            ex_valid       <= 1'b0;
            ex_pc_plus4    <= '0;
            ex_rs_data     <= '0;
            ex_rt_data     <= '0;
            ex_imm         <= '0;
            ex_rs          <= '0;
            ex_rt          <= '0;
            ex_rd          <= '0;
            ex_alu_src     <= 1'b0;
            ex_reg_dst     <= 1'b0;
            ex_reg_write   <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_mem_to_reg  <= 1'b0;
            ex_branch      <= 1'b0;
            ex_alu_ctrl_op <= 2'b00;
        end else if (!stall) begin
            ex_valid       <= id_valid;
            ex_pc_plus4    <= id_pc_plus4;
            ex_rs_data     <= id_rs_data;
            ex_rt_data     <= id_rt_data;
            ex_imm         <= id_imm;
            ex_rs          <= id_rs;
            ex_rt          <= id_rt;
            ex_rd          <= id_rd;
            ex_alu_src     <= id_alu_src;
            ex_reg_dst     <= id_reg_dst;
            ex_reg_write   <= id_reg_write;
            ex_mem_read    <= id_mem_read;
            ex_mem_write   <= id_mem_write;
            ex_mem_to_reg  <= id_mem_to_reg;
            ex_branch      <= id_branch;
            ex_alu_ctrl_op <= id_alu_ctrl_op;
        end
    end

    // Operand forwarding: the younger EX/MEM result beats MEM/WB; $0 is never forwarded.
    always_comb begin
        fwd_rs = ex_rs_data;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_rs)
            fwd_rs = exmem_result;
        else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_rs)
            fwd_rs = memwb_result;

        fwd_rt = ex_rt_data;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_rt)
            fwd_rt = exmem_result;
        else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_rt)
            fwd_rt = memwb_result;
    end

    // Operand selection, destination choice and branch target for EX.
    always_comb begin
        alu_data_in_1    = fwd_rs;
        alu_data_in_2    = ex_alu_src ? ex_imm : fwd_rt;
        ex_store_data    = fwd_rt;
        ex_write_reg     = ex_reg_dst ? ex_rd : ex_rt;
        ex_branch_target = ex_pc_plus4 + (ex_imm << 2);
    end

    id_ex_stage_alu_control u_alu_control (
        .alu_ctrl_op (ex_alu_ctrl_op),
        .funct       (ex_imm[5:0]),
        .op          (alu_op)
    );

endmodule
